// File: rtl/scan_teclado_pkg.sv
// ---------------------------------------------------------------------------
// pkg_teclado
// Shared definitions for the keypad matrix scanner:
//   - scan FSM state encoding (SCAN / DEBOUNCE / VALID / RELEASE)
//   - matrix geometry (4 columns x 2 rows) and key-code width
//   - idle patterns for column strobes and row returns
//   - helpers: one-hot-low column strobe decode, row-sample validity test
// ---------------------------------------------------------------------------
package pkg_teclado;

  localparam int NUM_COL = 4;
  localparam int NUM_FIL = 2;
  localparam int CODE_W  = 3;

  // All strobes inactive (active-low lines), and "no key" on the row returns.
  localparam logic [NUM_COL-1:0] COL_IDLE   = 4'b1111;
  localparam logic [NUM_FIL-1:0] FILAS_IDLE = 2'b11;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    VALID    = 2'd2,
    RELEASE  = 2'd3
  } estado_t;

  // Active-low one-hot strobe: only the selected column is pulled low.
  function automatic logic [NUM_COL-1:0] col_strobe(input logic [1:0] idx);
    logic [NUM_COL-1:0] s;
    s      = COL_IDLE;
    s[idx] = 1'b0;
    return s;
  endfunction

  // Exactly one row low is a usable key. Both rows low is ghosting from two
  // keys sharing a column and is deliberately treated the same as no key.
  function automatic logic fila_valida(input logic [NUM_FIL-1:0] f);
    return (f == 2'b10) || (f == 2'b01);
  endfunction

endpackage

// File: rtl/scan_teclado_if.sv
// ---------------------------------------------------------------------------
// scan_teclado_if
// Pin/consumer bundle of the keypad scanner.
//   filas         : row returns, active-low, already synchronised to clk
//   columnas      : column strobes, active-low one-hot
//   teclaoprimida : last validated key code {row_idx, col_idx}
//   done          : one-cycle pulse when teclaoprimida is updated
//   ocupado       : a key is being validated or is still held
// modport master : the scanner itself
// modport slave  : keypad pins + access-control FSM side
// ---------------------------------------------------------------------------
interface scan_teclado_if;
  import pkg_teclado::*;

  logic [NUM_FIL-1:0] filas;
  logic [NUM_COL-1:0] columnas;
  logic [CODE_W-1:0]  teclaoprimida;
  logic               done;
  logic               ocupado;

  modport master (
    input  filas,
    output columnas,
    output teclaoprimida,
    output done,
    output ocupado
  );

  modport slave (
    output filas,
    input  columnas,
    input  teclaoprimida,
    input  done,
    input  ocupado
  );

endinterface

// File: rtl/scan_teclado_contador.sv
// ---------------------------------------------------------------------------
// contador_teclado
// Shared dwell/debounce counter for the keypad scanner.
//   clk, reset : clock, synchronous active-low reset
//   clear      : return to zero next cycle (wins over enable)
//   enable     : count up by one
//   limite     : terminal value to compare against
//   terminal   : high while the count equals limite
// The owner clears the counter whenever it reaches its limit, so it never
// wraps or runs past the larger of the two limits.
// ---------------------------------------------------------------------------
module contador_teclado #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limite,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority so a state change always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == limite);

endmodule

// File: rtl/scan_teclado.sv
// ---------------------------------------------------------------------------
// scan_teclado
// Drive-side scanner for the 4x2 bicycle-rack keypad. Walks an active-low
// strobe across the columns, samples the row returns at the end of each
// column dwell, debounces press and release, and reports each key once.
//   clk    : system clock
//   reset  : synchronous, active-low
//   bus    : scan_teclado_if.master (filas in; columnas, teclaoprimida,
//            done, ocupado out)
// Parameters:
//   SCAN_DIV   : cycles each column is held while scanning (>=2)
//   DEB_CYCLES : consecutive identical samples for press and release (>=2)
//   CNT_W      : counter width, must hold max(SCAN_DIV, DEB_CYCLES)
// ---------------------------------------------------------------------------
module scan_teclado
  import pkg_teclado::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
  scan_teclado_if.master bus
);

  localparam logic [CNT_W-1:0] SCAN_LIM = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_CYCLES - 1);

  estado_t            state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [NUM_FIL-1:0] pat_q, pat_d;
  logic [NUM_COL-1:0] columnas_q, columnas_d;
  logic [CODE_W-1:0]  tecla_q, tecla_d;
  logic               done_q, done_d;
  logic               ocupado_q, ocupado_d;

  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_terminal;
  logic [CNT_W-1:0]   cnt_limit;

  // One counter serves both the column dwell and the debounce windows; the
  // terminal value is chosen from the current state only.
  assign cnt_limit = (state_q == SCAN) ? SCAN_LIM : DEB_LIM;

  contador_teclado #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .limite   (cnt_limit),
    .terminal (cnt_terminal)
  );

  // Next-state logic. Every state change also clears the counter, so each
  // state starts its own count from zero.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    pat_d      = pat_q;
    tecla_d    = tecla_q;
    done_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      SCAN: begin
        if (cnt_terminal) begin
          cnt_clear = 1'b1;
          if (fila_valida(bus.filas)) begin
            // Keep this column and remember which row answered.
            pat_d   = bus.filas;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end

      DEBOUNCE: begin
        if (bus.filas == pat_q) begin
          if (cnt_terminal) begin
            cnt_clear = 1'b1;
            state_d   = VALID;
          end else begin
            cnt_enable = 1'b1;
          end
        end else begin
          // Bounce, release or ghost: give up on this column for now.
          cnt_clear = 1'b1;
          col_d     = col_q + 2'd1;
          state_d   = SCAN;
        end
      end

      VALID: begin
        // Row 1 is the pattern with bit 1 low (2'b01).
        cnt_clear = 1'b1;
        tecla_d   = {~pat_q[1], col_q};
        done_d    = 1'b1;
        state_d   = RELEASE;
      end

      RELEASE: begin
        if (bus.filas == FILAS_IDLE) begin
          if (cnt_terminal) begin
            cnt_clear = 1'b1;
            col_d     = col_q + 2'd1;
            state_d   = SCAN;
          end else begin
            cnt_enable = 1'b1;
          end
        end else begin
          cnt_clear = 1'b1;
        end
      end

      default: begin
        cnt_clear = 1'b1;
        state_d   = SCAN;
      end
    endcase

    ocupado_d  = (state_d != SCAN);
    columnas_d = col_strobe(col_d);
  end

  // All outputs are registered; the strobe register always mirrors col_q so
  // exactly one column is low in every cycle, including right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      pat_q      <= FILAS_IDLE;
      columnas_q <= col_strobe(2'd0);
      tecla_q    <= '0;
      done_q     <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pat_q      <= pat_d;
      columnas_q <= columnas_d;
      tecla_q    <= tecla_d;
      done_q     <= done_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.columnas      = columnas_q;
  assign bus.teclaoprimida = tecla_q;
  assign bus.done          = done_q;
  assign bus.ocupado       = ocupado_q;

endmodule
